// File: rtl/ex_pkg.sv
// Shared definitions for the EX/MEM pipeline stage.
package ex_pkg;

    localparam int EX_XLEN    = 32;
    localparam int EX_RADDR_W = 5;

    // ALUFn codes
    localparam logic [4:0] FN_AND = 5'b00000;
    localparam logic [4:0] FN_OR  = 5'b00001;
    localparam logic [4:0] FN_ADD = 5'b00010;
    localparam logic [4:0] FN_XOR = 5'b00011;
    localparam logic [4:0] FN_SLL = 5'b00100;
    localparam logic [4:0] FN_SUB = 5'b00110;
    localparam logic [4:0] FN_SRL = 5'b01000;

    // Branch types; codes 5..7 behave as BR_NONE
    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;

    // Buffer occupancy
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    typedef struct packed {
        logic [EX_XLEN-1:0]    alu;
        logic [EX_XLEN-1:0]    st_data;
        logic [EX_RADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
    } entry_t;

endpackage

// File: rtl/skid_buf2.sv
// Generic 2-entry valid/ready skid buffer. in_ready is registered and
// depends only on occupancy, so the upstream path carries no combinational
// dependency on out_ready.
//
// state     | meaning
// OCC_EMPTY | no entries, out_valid low
// OCC_ONE   | head valid, tail free
// OCC_TWO   | head and tail valid, in_ready low
module skid_buf2
    import ex_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] data_o
);

    occ_e         state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         in_ready_q;
    logic         accept;
    logic         pop;

    assign accept      = in_valid_i & in_ready_q;
    assign pop         = (state_q != OCC_EMPTY) & out_ready_i;
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q != OCC_EMPTY);
    assign data_o      = head_q;

    // Next occupancy and entry movement; flush overrides everything
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            OCC_EMPTY: begin
                if (accept) begin
                    head_d  = data_i;
                    state_d = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (accept && pop) begin
                    head_d = data_i;
                end else if (accept) begin
                    tail_d  = data_i;
                    state_d = OCC_TWO;
                end else if (pop) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = OCC_ONE;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
        if (flush_i) begin
            state_d = OCC_EMPTY;
            head_d  = head_q;
            tail_d  = tail_q;
        end
    end

    // State, storage and registered ready
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= OCC_EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= (state_d != OCC_TWO);
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM stage: buffers ALU results, resolves branches and tracks the
// sticky overflow exception.
module ex_mem_stage
    import ex_pkg::*;
#(
    parameter int XLEN    = EX_XLEN,
    parameter int RADDR_W = EX_RADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    alu_out,
    input  logic               alu_zero,
    input  logic               alu_ng,
    input  logic               alu_ovf,
    input  logic [4:0]         alu_fn,
    input  logic [XLEN-1:0]    pc,
    input  logic [XLEN-1:0]    imm,
    input  logic [XLEN-1:0]    st_data,
    input  logic [RADDR_W-1:0] rd,
    input  logic               reg_write,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [2:0]         br_type,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_alu,
    output logic [XLEN-1:0]    out_st_data,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_reg_write,
    output logic               out_mem_read,
    output logic               out_mem_write,
    output logic               redirect,
    output logic [XLEN-1:0]    redirect_pc,
    output logic               exc_ovf,
    output logic [XLEN-1:0]    exc_pc,
    input  logic               exc_clr
);

    entry_t            entry_in, head;
    logic              br_taken;
    logic              ovf_hit;
    logic              acc_eff;
    logic              redirect_q;
    logic [XLEN-1:0]   redirect_pc_q;
    logic              exc_ovf_q;
    logic [XLEN-1:0]   exc_pc_q;

    // An accept that coincides with flush has no side effects at all
    assign acc_eff = in_valid & in_ready & ~flush;
    assign ovf_hit = alu_ovf & ((alu_fn == FN_ADD) | (alu_fn == FN_SUB));

    // Branch condition from ALU flags
    always_comb begin
        br_taken = 1'b0;
        case (br_type)
            BR_BEQ:  br_taken = alu_zero;
            BR_BNE:  br_taken = ~alu_zero;
            BR_BLT:  br_taken = alu_ng;
            BR_BGE:  br_taken = ~alu_ng;
            default: br_taken = 1'b0;
        endcase
    end

    // Branches write nothing; overflowing ops must not commit results
    always_comb begin
        entry_in.alu       = alu_out;
        entry_in.st_data   = st_data;
        entry_in.rd        = rd;
        entry_in.reg_write = reg_write & ~br_taken & ~ovf_hit;
        entry_in.mem_read  = mem_read & ~br_taken;
        entry_in.mem_write = mem_write & ~br_taken & ~ovf_hit;
    end

    skid_buf2 #(.W($bits(entry_t))) u_buf (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .data_i      (entry_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .data_o      (head)
    );

    assign out_alu       = head.alu;
    assign out_st_data   = head.st_data;
    assign out_rd        = head.rd;
    assign out_reg_write = head.reg_write;
    assign out_mem_read  = head.mem_read;
    assign out_mem_write = head.mem_write;

    // Redirect pulse and sticky overflow; a new overflow beats exc_clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            exc_ovf_q     <= 1'b0;
            exc_pc_q      <= '0;
        end else begin
            redirect_q <= acc_eff & br_taken;
            if (acc_eff && br_taken) begin
                redirect_pc_q <= pc + imm;
            end
            if (acc_eff && ovf_hit && (!exc_ovf_q || exc_clr)) begin
                exc_ovf_q <= 1'b1;
                exc_pc_q  <= pc;
            end else if (exc_clr) begin
                exc_ovf_q <= 1'b0;
            end
        end
    end

    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign exc_ovf     = exc_ovf_q;
    assign exc_pc      = exc_pc_q;

endmodule
